// File: rtl/m2s_pipe.sv
// m2s_pipe: forward-registered valid/ready slice with STAGES register stages.
// Valid/data are fully registered; ready ripples back combinationally so empty stages absorb bubbles.
module m2s_pipe #(
    parameter int DATA_WIDTH = 256,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pipe_in_valid,
    input  logic [DATA_WIDTH-1:0]         pipe_in_data,
    output logic                          pipe_in_ready,
    output logic                          pipe_out_valid,
    output logic [DATA_WIDTH-1:0]         pipe_out_data,
    input  logic                          pipe_out_ready,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);
    localparam int OW = $clog2(STAGES+1);

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("m2s_pipe: STAGES must be in 1..8");
    end

    logic [STAGES-1:0]     valid_q, valid_d, rdy, up_v;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] up_d [STAGES];
    logic [OW-1:0]         occ_q, occ_d;
    logic                  tail_full;

    assign up_v = STAGES'({valid_q, pipe_in_valid});

    // A stage is ready unless it and every stage after it are full and the output is stalled.
    always_comb begin
        tail_full = 1'b1;
        rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            tail_full = tail_full && valid_q[i];
            rdy[i] = !tail_full || pipe_out_ready;
        end
    end

    always_comb begin
        up_d[0] = pipe_in_data;
        for (int i = 1; i < STAGES; i++) up_d[i] = data_q[i-1];
    end

    assign valid_d = (rdy & up_v) | (~rdy & valid_q);

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) occ_d = occ_d + OW'(valid_d[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            occ_q <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (rdy[i] && up_v[i]) data_q[i] <= up_d[i];
        end
    end

    assign pipe_in_ready = rdy[0] && reset_n;
    assign pipe_out_valid = valid_q[STAGES-1];
    assign pipe_out_data = data_q[STAGES-1];
    assign occupancy = occ_q;
endmodule

// File: doc/m2s_pipe.md
Name: m2s_pipe

Overview:
- Forward-registered pipeline slice for valid/ready streams. It cuts the valid/data timing path (upstream to downstream) with STAGES register stages.
- The ready path stays combinational back through the stages, which is the complementary cut to the ready-path slice used on the same interfaces.
- Sits between two valid/ready blocks on long forward routes.
- Full throughput of 1 beat/cycle; fixed latency of STAGES cycles when not stalled.

Parameters:
DATA_WIDTH, 256, payload width in bits
STAGES, 2, number of forward register stages; legal range 1..8; any other value is an elaboration error

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
pipe_in_valid  input  1  upstream beat valid
pipe_in_data  input  DATA_WIDTH  upstream payload
pipe_in_ready  output  1  slice accepts beat this cycle
pipe_out_valid  output  1  registered; last stage holds a beat
pipe_out_data  output  DATA_WIDTH  registered payload of last stage
pipe_out_ready  input  1  downstream accepts beat
occupancy  output  $clog2(STAGES+1)  registered count of stages holding a beat

Behaviour:
- Reset: one clock is clk; reset is synchronous and active-low (reset_n sampled on rising edge of clk).
  - With reset_n=0 at an edge: all stage valid bits <=0 and occupancy <=0.
  - Data registers are not reset.
  - While reset_n=0, pipe_in_ready is forced to 0.
  - After reset: pipe_out_valid=0, occupancy=0, pipe_in_ready=1.
- Stages are indexed 0 (input side) to STAGES-1 (output side). valid[i] and data[i] are per-stage registers.
- Per-stage ready (combinational):
  - rdy[STAGES-1] = !valid[STAGES-1] || pipe_out_ready
  - rdy[i] = !valid[i] || rdy[i+1]
- pipe_in_ready = rdy[0] && reset_n.
- Stage update at each edge (reset_n=1), for each i with rdy[i]=1:
  - valid[i] <= upstream valid, where upstream for stage 0 is pipe_in_valid and for stage i is valid[i-1].
  - data[i] <= upstream data, loaded only when upstream valid=1; otherwise data[i] holds.
- If rdy[i]=0, stage i holds both valid and data.
- Outputs: pipe_out_valid = valid[STAGES-1]; pipe_out_data = data[STAGES-1]. No combinational path from any input to pipe_out_valid or pipe_out_data.
- Transfer rules:
  - A beat is accepted when pipe_in_valid && pipe_in_ready.
  - A beat is delivered when pipe_out_valid && pipe_out_ready.
  - pipe_out_valid/pipe_out_data must stay stable while pipe_out_valid=1 and pipe_out_ready=0.
- Latency: an accepted beat appears on pipe_out_valid exactly STAGES cycles later if pipe_out_ready was held 1.
- Throughput: with pipe_out_ready=1 continuously, 1 beat/cycle with no bubbles inserted.
- Bubble collapse: an empty stage accepts even when downstream is stalled, so gaps squeeze out during backpressure.
- Full: all STAGES valid and pipe_out_ready=0 gives pipe_in_ready=0 in the same cycle.
- Simultaneous events: full with pipe_out_ready=1 gives pipe_in_ready=1. That cycle delivers one beat and accepts one; occupancy is unchanged.
- Occupancy: next value = popcount of the next-state valid bits. Range 0..STAGES; never wraps.
- Ordering: beats are never dropped, duplicated or reordered.
- Reset mid-operation: all in-flight beats are discarded, with no output beat on the following cycle.
- Upstream dropping pipe_in_valid without acceptance is legal; the slice ignores it.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles with pipe_in_valid=1, data=0xA5 -> pipe_in_ready=0, pipe_out_valid=0, occupancy=0. After release: pipe_in_ready=1, and no beat emerges from the data driven during reset.
- Latency/streaming (STAGES=2): send data 1..16 back-to-back with pipe_out_ready=1 -> first beat (1) valid at cycle 2 after acceptance, then 1..16 on 16 consecutive cycles, occupancy steady at 2.
- Backpressure/full: STAGES=2, pipe_out_ready=0, send 1,2,3 -> 1 and 2 accepted, occupancy=2, pipe_in_ready=0, 3 held. Raise pipe_out_ready -> 1,2,3 delivered in order with pipe_out_data stable during the stall.
- Bubble collapse: STAGES=4, send 0x10 then one idle cycle then 0x11, with pipe_out_ready=0 -> both absorbed, occupancy=2, pipe_in_ready=1. Release -> 0x10 and 0x11 emitted on consecutive cycles.
- Full with simultaneous pop/push: STAGES=3 filled with 7,8,9, then pipe_out_ready=1 and push 10 in the same cycle -> 7 delivered, 10 accepted, occupancy stays 3.
- Random soak plus mid-stream reset: random valid/ready (50%) for STAGES=1 and 8, 10k beats against a scoreboard -> exact in-order match. A reset_n pulse mid-stream -> occupancy=0 the next cycle, scoreboard flushed, no stale beat appears.
